// File: rtl/int_control.sv
// Interrupt controller: edge-latched pending bits, mask, fixed lowest-index priority,
// and a request/acknowledge/service sequencer for fetch control. Request output is int_req ("int" is reserved).
module int_control #(
   parameter int NUM_SRC     = 4,
   parameter int VEC_W       = 2,
   parameter int ACK_TIMEOUT = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] irq,
   input  logic [NUM_SRC-1:0] mask,
   input  logic               int_ack,
   input  logic               rti,
   output logic               int_req,
   output logic [VEC_W-1:0]   vector,
   output logic               in_service,
   output logic [NUM_SRC-1:0] pending
);

   localparam int CNT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, SERVICE} state_t;

   state_t             state, state_n;
   logic [NUM_SRC-1:0] irq_prev;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic [NUM_SRC-1:0] rise, eligible, clr, pending_n;
   logic [VEC_W-1:0]   win, vector_n;
   logic               found;
   logic               svc_n;

   assign rise     = irq & ~irq_prev;
   assign eligible = pending & ~mask;

   always_comb begin
      win   = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (!found && eligible[i]) begin
            win   = VEC_W'(i);
            found = 1'b1;
         end
      end
   end

   always_comb begin
      state_n  = state;
      vector_n = vector;
      svc_n    = in_service;
      cnt_n    = cnt;
      clr      = '0;
      case (state)
         IDLE: begin
            if (found) begin
               vector_n = win;
               state_n  = REQ;
            end
         end
         REQ: begin
            cnt_n   = '0;
            state_n = WAIT;
         end
         WAIT: begin
            // acknowledge takes precedence over an expiring timeout
            if (int_ack) begin
               state_n = SERVICE;
               svc_n   = 1'b1;
               for (int unsigned i = 0; i < NUM_SRC; i++)
                  clr[i] = (vector == VEC_W'(i));
            end else if (cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
               state_n = REQ;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         SERVICE: begin
            if (rti) begin
               svc_n   = 1'b0;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
      // a new edge on the bit being cleared keeps it pending
      pending_n = (pending & ~clr) | rise;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         irq_prev   <= '0;
         pending    <= '0;
         vector     <= '0;
         int_req    <= 1'b0;
         in_service <= 1'b0;
         cnt        <= '0;
      end else begin
         state      <= state_n;
         irq_prev   <= irq;
         pending    <= pending_n;
         vector     <= vector_n;
         int_req    <= (state_n == REQ);
         in_service <= svc_n;
         cnt        <= cnt_n;
      end
   end

endmodule

// File: tb/tb_int_control.sv
// Scoreboard bench for int_control: stimulus queues expected request pulses (vector and cycle),
// a negedge monitor checks every int_req pulse against the queue.
module tb_int_control;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] irq;
   logic [3:0] mask;
   logic       int_ack;
   logic       rti;
   logic       int_req;
   logic [1:0] vector;
   logic       in_service;
   logic [3:0] pending;

   typedef struct {
      logic [1:0]  v;
      int unsigned c;
   } exp_t;

   exp_t        q[$];
   int unsigned cyc = 0;
   int unsigned total = 0;
   int unsigned bad = 0;
   logic        prev_int = 1'b0;

   int_control #(.NUM_SRC(4), .VEC_W(2), .ACK_TIMEOUT(8)) dut (
      .clk(clk), .rst(rst), .irq(irq), .mask(mask), .int_ack(int_ack), .rti(rti),
      .int_req(int_req), .vector(vector), .in_service(in_service), .pending(pending)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic expect_int(input logic [1:0] v, input int unsigned c);
      exp_t e;
      e.v = v;
      e.c = c;
      q.push_back(e);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         prev_int = 1'b0;
      end else begin
         if (int_req) begin
            chk("int_gap", {31'd0, prev_int}, 32'd0);
            if (q.size() == 0) begin
               chk("int_unexpected", {31'd0, int_req}, 32'd0);
            end else begin
               e = q.pop_front();
               chk("int_vector", {30'd0, vector}, {30'd0, e.v});
               chk("int_cycle", cyc, e.c);
            end
         end
         prev_int = int_req;
      end
   end

   initial begin
      rst = 1'b1; irq = '0; mask = '0; int_ack = 1'b0; rti = 1'b0;
      step(3);
      rst = 1'b0;

      // reset and quiet status
      for (int i = 0; i < 10; i++) begin
         step(1);
         chk("reset_idle", {24'd0, int_req, vector, in_service, pending}, 32'd0);
      end

      // single interrupt on line 2
      irq = 4'b0100;
      expect_int(2'd2, cyc + 2);
      step(1);
      chk("single_pending", {28'd0, pending}, 32'h4);
      step(1);
      chk("single_req_vec", {30'd0, vector}, 32'd2);
      step(1);
      int_ack = 1'b1; step(1); int_ack = 1'b0;
      chk("single_ack", {27'd0, in_service, pending}, 32'h10);
      rti = 1'b1; step(1); rti = 1'b0;
      chk("single_rti", {31'd0, in_service}, 32'd0);

      // lines 3 and 1 together, line 1 masked
      mask = 4'b0010;
      irq = 4'b1010;
      expect_int(2'd3, cyc + 2);
      step(3);
      int_ack = 1'b1; step(1); int_ack = 1'b0;
      chk("prio_ack", {27'd0, in_service, pending}, 32'h12);
      rti = 1'b1; step(1); rti = 1'b0;
      step(2);
      chk("mask_holds", {27'd0, in_service, pending}, 32'h02);
      mask = 4'b0000;
      expect_int(2'd1, cyc + 1);
      step(2);
      int_ack = 1'b1; step(1); int_ack = 1'b0;
      rti = 1'b1; step(1); rti = 1'b0;
      chk("unmask_done", {27'd0, in_service, pending}, 32'h00);

      // acknowledge timeout on line 0
      irq = 4'b0001;
      expect_int(2'd0, cyc + 2);
      expect_int(2'd0, cyc + 11);
      step(12);
      int_ack = 1'b1; step(1); int_ack = 1'b0;
      chk("late_ack", {27'd0, in_service, pending}, 32'h10);
      rti = 1'b1; step(1); rti = 1'b0;

      // new rise on line 1 coinciding with its acknowledge
      irq = 4'b0011;
      expect_int(2'd1, cyc + 2);
      step(3);
      irq = 4'b0001; step(1);
      irq = 4'b0011; int_ack = 1'b1; step(1); int_ack = 1'b0;
      chk("collide", {27'd0, in_service, pending}, 32'h12);
      rti = 1'b1;
      expect_int(2'd1, cyc + 2);
      step(1); rti = 1'b0;
      step(2);
      int_ack = 1'b1; step(1); int_ack = 1'b0;
      rti = 1'b1; step(1); rti = 1'b0;
      chk("collide_done", {27'd0, in_service, pending}, 32'h00);

      // reset while in service with line 3 pending
      irq = 4'b0111;
      expect_int(2'd2, cyc + 2);
      step(2);
      irq = 4'b1111; step(1);
      int_ack = 1'b1; step(1); int_ack = 1'b0;
      chk("pre_reset", {27'd0, in_service, pending}, 32'h18);
      rst = 1'b1; irq = 4'b0000; step(1);
      chk("mid_reset", {24'd0, int_req, vector, in_service, pending}, 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step(1);
         chk("post_reset", {24'd0, int_req, vector, in_service, pending}, 32'd0);
      end
      irq = 4'b1000;
      expect_int(2'd3, cyc + 2);
      step(3);
      int_ack = 1'b1; step(1); int_ack = 1'b0;
      rti = 1'b1; step(1); rti = 1'b0;

      for (int i = 0; i < 50 && q.size() != 0; i++) step(1);
      chk("int_missing", q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/int_control.md
# int_control

Interrupt controller that sequences the fetch unit's interrupt path. It latches rising edges on `NUM_SRC` external interrupt lines and applies a mask and fixed priority. It issues a one-cycle `int` request to fetch control and tracks the request through acknowledge and service until return-from-interrupt. It sits between the external interrupt pins and fetch control, and drives the interrupt vector select consumed by the fetch-address logic.

## Interface
Parameters:
- `NUM_SRC`, 4, number of interrupt request lines (2..8)
- `VEC_W`, 2, vector index width; must satisfy 2**VEC_W >= NUM_SRC
- `ACK_TIMEOUT`, 8, cycles to wait for `int_ack` before re-issuing `int` (>= 2)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset; synchronous, active-high
- `irq`  in  NUM_SRC  level interrupt lines, synchronous to `clk`
- `mask`  in  NUM_SRC  1 = source disabled; pending bits are still captured
- `int_ack`  in  1  single-cycle pulse: pipeline has fetched from the interrupt vector
- `rti`  in  1  single-cycle pulse: return-from-interrupt has committed
- `int`  out  1  registered; one-cycle interrupt request to fetch control
- `vector`  out  VEC_W  registered index of the source being requested or serviced
- `in_service`  out  1  registered; high from acknowledge until `rti`
- `pending`  out  NUM_SRC  registered pending bits, for status readout

## Operation
- Edge detect: `irq_prev` holds the previous cycle's `irq`. `rise = irq & ~irq_prev`, and `pending[i]` sets when `rise[i]` is 1. Reset clears `irq_prev` to 0, so a line already high when reset releases counts as an edge on the first sampled cycle.
- Eligible set: `pending & ~mask`. Priority is fixed: the lowest index wins.
- FSM states: IDLE, REQ, WAIT, SERVICE.
  - IDLE: if the eligible set is non-empty, latch the winner into `vector` and go to REQ. Otherwise stay in IDLE.
  - REQ: `int` = 1 for this single cycle. Clear the timeout counter, then go to WAIT.
  - WAIT: `int` = 0 and the counter increments each cycle.
    - If `int_ack` arrives: clear `pending[vector]`, set `in_service`, go to SERVICE.
    - Otherwise, if the counter reaches ACK_TIMEOUT-1: go to REQ, which re-issues `int` with the same `vector`.
  - SERVICE: hold `vector`. On `rti`, clear `in_service` and go to IDLE.
- No nesting. New edges accumulate in `pending` during REQ, WAIT and SERVICE, but are not arbitrated until IDLE.
- The vector is locked once latched. Masking the latched source, or a higher-priority edge arriving, after the REQ transition does not change `vector` or abort the sequence.
- Set and clear on the same bit in the same cycle (rise on `irq[vector]` coincident with `int_ack`): set wins, so the bit stays 1.
- `int_ack` outside WAIT and `rti` outside SERVICE are ignored.
- `int_ack` on the cycle the timeout expires: the acknowledge wins, and the FSM goes to SERVICE.

## Timing
- Reset values: state IDLE, `int` 0, `vector` 0, `in_service` 0, `pending` all 0, `irq_prev` all 0, counter 0. Reset overrides all other inputs in the same cycle.
- Latency from edge to request:
  - `irq[i]` is first sampled high at edge k, so `pending[i]` = 1 after edge k.
  - With the FSM in IDLE, the FSM enters REQ at edge k+1.
  - `int` is high for exactly the cycle between edges k+1 and k+2.
- `int_ack` sampled at edge m (in WAIT): `pending[vector]` = 0 and `in_service` = 1 after edge m.
- `rti` sampled at edge r: `in_service` = 0 after edge r. A remaining eligible source gives REQ after edge r+1, so the minimum back-to-back `int` spacing after `rti` is 2 cycles.
- Timeout: `int` re-pulses exactly ACK_TIMEOUT+1 cycles after the previous pulse when no acknowledge arrives.
- `int` is never high on two consecutive cycles.

## Test plan
- Reset and status: hold `irq` = 4'b0000 through reset, release, and wait 10 cycles. Required: `int` = 0, `pending` = 0, `in_service` = 0, `vector` = 0 throughout.
- Single interrupt: `irq[2]` rises with `mask` = 0. Required:
  - `pending` = 4'b0100 one cycle later, and `int` pulses one cycle after that with `vector` = 2.
  - `int_ack` gives `in_service` = 1 and `pending` = 0.
  - `rti` gives `in_service` = 0.
- Priority and mask: `irq[3]` and `irq[1]` rise together, `mask` = 4'b0010. Required:
  - `vector` = 3 serviced first.
  - After `rti`, unmasking bit 1 gives `int` with `vector` = 1.
- Timeout: `irq[0]` rises and `int_ack` is never sent (ACK_TIMEOUT = 8). Required:
  - `int` pulses again 9 cycles after the first pulse, with `vector` = 0 both times.
  - A late `int_ack` then moves the FSM to SERVICE.
- Set/clear collision: pulse `irq[1]` low then high so a new rise coincides with `int_ack` for `vector` = 1. Required:
  - `pending[1]` stays 1.
  - After `rti`, a second `int` with `vector` = 1.
- Reset mid-operation: assert `rst` in SERVICE with `pending` = 4'b1000. Required: all outputs return to reset values the next cycle, with no `int` until a new rising edge.
